updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
Parametrised up/down counter, the next generation of the team's 4-bit load/up/down counter. Adds:
- configurable width and modulus
- count enable and programmable step
- wrap or saturate mode
- registered wrap/terminal/compare flags

It is the general-purpose event/timer counter for datapath and control blocks that need modulo-N or clamped counting with status pulses.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MOD_MAX, 2**WIDTH-1, highest legal count value; count range is 0..MOD_MAX
STEP_W, 4, width of step input
SATURATE, 0, 0 = wrap at bounds, 1 = clamp at bounds

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
ld  in  1  load d into q
d  in  WIDTH  load value
en  in  1  count enable
und  in  1  direction: 1 = up, 0 = down
step  in  STEP_W  increment magnitude; 0 = hold
cmp  in  WIDTH  compare value
q  out  WIDTH  current count
wrap  out  1  one-cycle pulse: last update crossed a bound (wrapped or clamped)
at_max  out  1  q == MOD_MAX (level)
at_min  out  1  q == 0 (level)
match  out  1  one-cycle pulse: q became equal to cmp on this update

Behaviour:
- Reset: synchronous, active-high, clock clk.
  - All outputs go to zero after the reset edge: q = 0, wrap = 0, match = 0.
  - at_min = 1 and at_max = 0 (combinational from q).
  - rst overrides ld and en.
- Priority per edge: rst > ld > (en && step != 0) > hold.
- Load:
  - q <= min(d, MOD_MAX); a d above MOD_MAX is clamped to MOD_MAX.
  - wrap <= 0.
  - match <= (loaded value == cmp).
  - ld acts regardless of en.
- Count, up, with s = step zero-extended:
  - Compute sum = q + s in WIDTH+2 bits.
  - If sum <= MOD_MAX: q <= sum, wrap <= 0.
  - Else, SATURATE = 0: q <= sum - (MOD_MAX+1); wrap <= 1.
  - Else, SATURATE = 1: q <= MOD_MAX; wrap <= 1 only if q was not already MOD_MAX.
- Count, down:
  - If q >= s: q <= q - s, wrap <= 0.
  - Else, SATURATE = 0: q <= q + (MOD_MAX+1) - s; wrap <= 1.
  - Else, SATURATE = 1: q <= 0; wrap <= 1 only if q was not already 0.
- Step larger than the modulus: wrap mode reduces s modulo (MOD_MAX+1) before the add/subtract. A single wrap only; wrap is still pulsed if the reduced step crosses the bound.
- Hold (en = 0, or step = 0, no ld): q unchanged; wrap <= 0; match <= 0.
- match:
  - Registered. It is 1 in the cycle after an update (load or count) whose new q equals cmp, and the new q differs from the old q or it was a load.
  - No repeated pulses while holding at cmp.
- Latency: q, wrap and match are valid one cycle after the controlling edge. at_max and at_min are combinational decodes of registered q.
- Direction changes take effect on the same edge; no pipeline state to flush.
- Reset mid-count: the next edge forces the reset values; no residual pulse.
- All arithmetic is unsigned. No X propagation from an unused step width.

Decomposition:
- Shared package updown_pkg holds:
  - the mode constants CNT_WRAP = 0 and CNT_SAT = 1
  - a function clamp_ld(d, max) used for load clamping
- One natural sub-module, updown_next_val: combinational next-value and crossing computation taking (q, step, und, MOD_MAX, SATURATE) and returning (nxt, crossed).
- The top level holds the registers, priority logic and flag generation.

Test Plan:
- WIDTH=8, MOD_MAX=9, wrap, step=1, up from reset: after 9 counts q=9 and at_max=1. Next edge q=0 with wrap=1 for exactly one cycle; at_min=1.
- Same config, und=0, step=3, ld d=1: next edge q=1. Then q=8 with wrap=1, then q=5, then q=2.
- SATURATE=1, MOD_MAX=255, ld d=250, step=4 up: q=254, then 255 with wrap=1, then 255 with wrap=0. Down from 2 with step=4: q=0 with wrap=1, then q=0 with wrap=0.
- ld d=200 with MOD_MAX=99: q=99 and at_max=1. Simultaneous rst=1, ld=1, en=1: q=0, all pulses 0.
- cmp=5, step=1 up from 0: match=1 only in the cycle q becomes 5. Then hold (en=0) at 5 for 3 cycles: match=0. Then ld d=5: match=1 again.
- en=1, step=0: q is held and wrap=0. Toggling und each cycle with step=2 from q=4 gives 6, 4, 6, 4 with no flags.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared mode constants and load-clamp helper for the up/down counter family.
// Latency: none (package only).
// Backpressure: not applicable.
package updown_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Operands are carried at 32 bits, so counters using this are limited to WIDTH <= 32.
    function automatic logic [31:0] clamp_ld(input logic [31:0] d, input logic [31:0] max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/updown_next_val.sv
// Next count value and bound-crossing flag for one up/down step.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is committed.
module updown_next_val
    import updown_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               STEP_W   = 4,
    parameter logic [WIDTH-1:0] MOD_MAX  = '1,
    parameter int               SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [STEP_W-1:0] step,
    input  logic              und,
    output logic [WIDTH-1:0]  nxt,
    output logic              crossed
);

    // Two guard bits keep q + step and q + modulus free of overflow.
    localparam int            EW    = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;
    localparam logic [EW-1:0] MAX_E = EW'(MOD_MAX);
    localparam logic [EW-1:0] MOD_E = MAX_E + EW'(1);

    logic [EW-1:0] q_e;
    logic [EW-1:0] s_e;
    logic [EW-1:0] sum;

    always_comb begin
        q_e     = EW'(q);
        s_e     = (SATURATE == CNT_WRAP) ? (EW'(step) % MOD_E) : EW'(step);
        sum     = q_e + s_e;
        nxt     = q;
        crossed = 1'b0;
        if (und) begin
            if (sum <= MAX_E) begin
                nxt = WIDTH'(sum);
            end else if (SATURATE == CNT_WRAP) begin
                nxt     = WIDTH'(sum - MOD_E);
                crossed = 1'b1;
            end else begin
                nxt     = MOD_MAX;
                crossed = (q != MOD_MAX);
            end
        end else begin
            if (q_e >= s_e) begin
                nxt = WIDTH'(q_e - s_e);
            end else if (SATURATE == CNT_WRAP) begin
                nxt     = WIDTH'(q_e + MOD_E - s_e);
                crossed = 1'b1;
            end else begin
                nxt     = '0;
                crossed = (q != '0);
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Modulo-N / saturating up/down counter with load, enable, step and status pulses.
// Latency: q, wrap, match one cycle after the controlling edge; at_max/at_min decode q.
// Backpressure: none; every edge is accepted.
module updown_counter_mod
    import updown_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MOD_MAX  = '1,
    parameter int               STEP_W   = 4,
    parameter int               SATURATE = CNT_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [WIDTH-1:0]  d,
    input  logic              en,
    input  logic              und,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  cmp,
    output logic [WIDTH-1:0]  q,
    output logic              wrap,
    output logic              at_max,
    output logic              at_min,
    output logic              match
);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld_val;
    logic             crossed;
    logic             cnt_go;

    updown_next_val #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .MOD_MAX  (MOD_MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .q       (q),
        .step    (step),
        .und     (und),
        .nxt     (nxt),
        .crossed (crossed)
    );

    assign ld_val = WIDTH'(clamp_ld(32'(d), 32'(MOD_MAX)));
    assign cnt_go = en && (step != '0);

    // A count that leaves q unchanged (clamped or full-modulus step) never re-fires match.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            wrap  <= 1'b0;
            match <= 1'b0;
        end else if (ld) begin
            q     <= ld_val;
            wrap  <= 1'b0;
            match <= (ld_val == cmp);
        end else if (cnt_go) begin
            q     <= nxt;
            wrap  <= crossed;
            match <= (nxt == cmp) && (nxt != q);
        end else begin
            wrap  <= 1'b0;
            match <= 1'b0;
        end
    end

    assign at_max = (q == MOD_MAX);
    assign at_min = (q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: three configurations share one stimulus stream.
// dut 0: mod 10 wrap, dut 1: mod 256 saturate, dut 2: mod 100 wrap.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst, ld, en, und;
    logic [7:0] d, cmp;
    logic [3:0] step;

    logic [7:0] q_o      [3];
    logic       wrap_o   [3];
    logic       at_max_o [3];
    logic       at_min_o [3];
    logic       match_o  [3];

    int checks = 0;
    int errors = 0;

    int mx  [3] = '{9, 255, 99};
    bit sat [3] = '{1'b0, 1'b1, 1'b0};
    int mq  [3] = '{0, 0, 0};
    bit mw  [3] = '{1'b0, 1'b0, 1'b0};
    bit mm  [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(8), .MOD_MAX(8'd9), .STEP_W(4), .SATURATE(0)) dut_wrap9 (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .en(en), .und(und), .step(step), .cmp(cmp),
        .q(q_o[0]), .wrap(wrap_o[0]), .at_max(at_max_o[0]), .at_min(at_min_o[0]), .match(match_o[0]));

    updown_counter_mod #(.WIDTH(8), .MOD_MAX(8'd255), .STEP_W(4), .SATURATE(1)) dut_sat255 (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .en(en), .und(und), .step(step), .cmp(cmp),
        .q(q_o[1]), .wrap(wrap_o[1]), .at_max(at_max_o[1]), .at_min(at_min_o[1]), .match(match_o[1]));

    updown_counter_mod #(.WIDTH(8), .MOD_MAX(8'd99), .STEP_W(4), .SATURATE(0)) dut_wrap99 (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .en(en), .und(und), .step(step), .cmp(cmp),
        .q(q_o[2]), .wrap(wrap_o[2]), .at_max(at_max_o[2]), .at_min(at_min_o[2]), .match(match_o[2]));

    // Reference: treat the count as an integer on a ring (wrap) or a clamped line (saturate).
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int m, s, raw, n;
            bit w;
            m = mx[k] + 1;
            if (rst) begin
                mq[k] = 0; mw[k] = 1'b0; mm[k] = 1'b0;
            end else if (ld) begin
                n     = (int'(d) > mx[k]) ? mx[k] : int'(d);
                mw[k] = 1'b0;
                mm[k] = (n == int'(cmp));
                mq[k] = n;
            end else if (en && step != 4'd0) begin
                s   = sat[k] ? int'(step) : int'(step) % m;
                raw = und ? mq[k] + s : mq[k] - s;
                if (sat[k]) begin
                    n = (raw > mx[k]) ? mx[k] : ((raw < 0) ? 0 : raw);
                    w = (n != raw) && (n != mq[k]);
                end else begin
                    n = ((raw % m) + m) % m;
                    w = (n != raw);
                end
                mm[k] = (n == int'(cmp)) && (n != mq[k]);
                mw[k] = w;
                mq[k] = n;
            end else begin
                mw[k] = 1'b0; mm[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] obs(input int k);
        return {q_o[k], wrap_o[k], match_o[k], at_max_o[k], at_min_o[k]};
    endfunction

    // Expected {q, wrap, match, at_max, at_min} for dut k.
    function automatic logic [11:0] ev(input int k, input int qv, input bit w, input bit m);
        return {8'(qv), w, m, qv == mx[k], qv == 0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; ld = 1'b1; en = 1'b1; und = 1'b1; step = 4'd1; d = 8'd200; cmp = 8'd150;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== ev(k, 0, 1'b0, 1'b0)) begin
                errors++; $display("FAIL reset dut%0d got %h exp %h", k, obs(k), ev(k, 0, 1'b0, 1'b0));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        ld = 1'b0; en = 1'b1; und = 1'b1; step = 4'd1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks++;
            if (obs(0) !== ev(0, i % 10, i == 10, 1'b0)) begin
                errors++; $display("FAIL wrap_up step %0d got %h exp %h", i, obs(0), ev(0, i % 10, i == 10, 1'b0));
            end
        end
    endtask

    task automatic test_wrap_down();
        int eq [4] = '{1, 8, 5, 2};
        bit ew [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        ld = 1'b1; d = 8'd1; und = 1'b0; step = 4'd3;
        for (int j = 0; j < 4; j++) begin
            tick();
            ld = 1'b0;
            checks++;
            if (obs(0) !== ev(0, eq[j], ew[j], 1'b0)) begin
                errors++; $display("FAIL wrap_down step %0d got %h exp %h", j, obs(0), ev(0, eq[j], ew[j], 1'b0));
            end
        end
    endtask

    task automatic test_saturate();
        bit ldv [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int dv  [7] = '{250, 0, 0, 0, 2, 0, 0};
        bit uv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int eq  [7] = '{250, 254, 255, 255, 2, 0, 0};
        bit ew  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        en = 1'b1; step = 4'd4;
        for (int j = 0; j < 7; j++) begin
            ld = ldv[j]; d = 8'(dv[j]); und = uv[j];
            tick();
            checks++;
            if (obs(1) !== ev(1, eq[j], ew[j], 1'b0)) begin
                errors++; $display("FAIL saturate step %0d got %h exp %h", j, obs(1), ev(1, eq[j], ew[j], 1'b0));
            end
        end
        ld = 1'b0;
    endtask

    task automatic test_big_step();
        ld = 1'b1; d = 8'd7; en = 1'b1;
        tick();
        ld = 1'b0; und = 1'b1; step = 4'd15;
        tick();
        checks++;
        if (obs(0) !== ev(0, 2, 1'b1, 1'b0)) begin
            errors++; $display("FAIL big_step_up got %h exp %h", obs(0), ev(0, 2, 1'b1, 1'b0));
        end
        cmp = 8'd2; und = 1'b0; step = 4'd10;
        tick();
        checks++;
        if (obs(0) !== ev(0, 2, 1'b0, 1'b0)) begin
            errors++; $display("FAIL big_step_full_mod got %h exp %h", obs(0), ev(0, 2, 1'b0, 1'b0));
        end
        cmp = 8'd150;
    endtask

    task automatic test_clamp_load();
        ld = 1'b1; d = 8'd200; en = 1'b1; und = 1'b1; step = 4'd1;
        tick();
        checks++;
        if (obs(2) !== ev(2, 99, 1'b0, 1'b0)) begin
            errors++; $display("FAIL clamp_ld_99 got %h exp %h", obs(2), ev(2, 99, 1'b0, 1'b0));
        end
        checks++;
        if (obs(0) !== ev(0, 9, 1'b0, 1'b0)) begin
            errors++; $display("FAIL clamp_ld_9 got %h exp %h", obs(0), ev(0, 9, 1'b0, 1'b0));
        end
        ld = 1'b0;
        tick();
        checks++;
        if (obs(2) !== ev(2, 0, 1'b1, 1'b0)) begin
            errors++; $display("FAIL clamp_wrap got %h exp %h", obs(2), ev(2, 0, 1'b1, 1'b0));
        end
        rst = 1'b1; ld = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== ev(k, 0, 1'b0, 1'b0)) begin
                errors++; $display("FAIL reset_mid dut%0d got %h exp %h", k, obs(k), ev(k, 0, 1'b0, 1'b0));
            end
        end
        rst = 1'b0; ld = 1'b0;
    endtask

    task automatic test_match();
        cmp = 8'd5; ld = 1'b0; en = 1'b1; und = 1'b1; step = 4'd1;
        for (int i = 1; i <= 9; i++) begin
            int eq;
            bit em;
            if (i == 6) en = 1'b0;
            if (i == 9) begin ld = 1'b1; d = 8'd5; end
            eq = (i < 5) ? i : 5;
            em = (i == 5) || (i == 9);
            tick();
            checks++;
            if (obs(0) !== ev(0, eq, 1'b0, em)) begin
                errors++; $display("FAIL match step %0d got %h exp %h", i, obs(0), ev(0, eq, 1'b0, em));
            end
        end
        ld = 1'b0;
        tick();
        checks++;
        if (obs(0) !== ev(0, 5, 1'b0, 1'b0)) begin
            errors++; $display("FAIL match_after_load got %h exp %h", obs(0), ev(0, 5, 1'b0, 1'b0));
        end
    endtask

    task automatic test_step_zero();
        cmp = 8'd150; en = 1'b1; step = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs(0) !== ev(0, 5, 1'b0, 1'b0)) begin
                errors++; $display("FAIL step_zero %0d got %h exp %h", i, obs(0), ev(0, 5, 1'b0, 1'b0));
            end
        end
        ld = 1'b1; d = 8'd4;
        tick();
        ld = 1'b0; step = 4'd2;
        for (int i = 0; i < 4; i++) begin
            int eq;
            und = (i % 2 == 0);
            eq  = (i % 2 == 0) ? 6 : 4;
            tick();
            checks++;
            if (obs(0) !== ev(0, eq, 1'b0, 1'b0)) begin
                errors++; $display("FAIL toggle_dir %0d got %h exp %h", i, obs(0), ev(0, eq, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(63) == 0);
            ld   = ($urandom_range(7) == 0);
            en   = ($urandom_range(3) != 0);
            und  = 1'($urandom);
            step = 4'($urandom);
            d    = 8'($urandom);
            cmp  = ($urandom_range(1) == 0) ? 8'($urandom_range(9)) : 8'($urandom);
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs(k) !== ev(k, mq[k], mw[k], mm[k])) begin
                    errors++;
                    $display("FAIL random cyc %0d dut%0d got %h exp %h", n, k, obs(k), ev(k, mq[k], mw[k], mm[k]));
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; en = 1'b0; und = 1'b0; step = 4'd0; d = 8'd0; cmp = 8'd0;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_big_step();
        test_clamp_load();
        test_match();
        test_step_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
